weight_fetch_sequencer: RTL and testbench

Controller that walks every output neuron of one ensemble sub-network and emits the weight-memory addresses belonging to it. Per neuron it reads the neuron's [begin, end) weight range from the weight-index memory (registered read, 1-cycle latency), then streams addresses begin..end-1 to the synaptic accumulate datapath over a valid/ready handshake. Sits between the inference top-level FSM (start/done) and the weight-index memory and weight memory.

---
 rtl/weight_fetch_sequencer_if.sv | 32 +++
 rtl/weight_fetch_sequencer.sv | 111 +++++++++++
 tb/tb_weight_fetch_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/weight_fetch_sequencer_if.sv
// Signal bundle between the weight fetch sequencer, its control FSM, the weight-index memory
// and the synaptic accumulate datapath.
interface weight_fetch_sequencer_if #(
    parameter int unsigned NIDX_W = 6,
    parameter int unsigned WIDX_W = 8
);
    logic              start;
    logic              busy;
    logic              done;
    logic              range_err;
    logic [NIDX_W-1:0] neuron_index;
    logic [WIDX_W-1:0] begin_index;
    logic [WIDX_W-1:0] end_index;
    logic [WIDX_W-1:0] addr;
    logic              addr_valid;
    logic              addr_ready;
    logic              addr_last;
    logic [NIDX_W-1:0] neuron_id;
    logic              neuron_done;

    modport master (
        input  start, begin_index, end_index, addr_ready,
        output busy, done, range_err, neuron_index, addr, addr_valid, addr_last, neuron_id,
               neuron_done
    );

    modport slave (
        output start, begin_index, end_index, addr_ready,
        input  busy, done, range_err, neuron_index, addr, addr_valid, addr_last, neuron_id,
               neuron_done
    );
endinterface

// File: rtl/weight_fetch_sequencer.sv
// Walks every neuron of a sub-network, looks up its [begin, end) weight range and streams
// the weight addresses over a valid/ready handshake.
module weight_fetch_sequencer #(
    parameter int unsigned NUM_NEURONS = 40,
    parameter int unsigned NIDX_W      = 6,
    parameter int unsigned WIDX_W      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    weight_fetch_sequencer_if.master  bus
);
    typedef enum logic [1:0] {StIdle, StLookup, StLatch, StStream} state_e;

    localparam logic [NIDX_W-1:0] LastNeuron = NIDX_W'(NUM_NEURONS - 1);

    state_e            state_q, state_d;
    logic [NIDX_W-1:0] cnt_q, cnt_d;
    logic [NIDX_W-1:0] id_q, id_d;
    logic [WIDX_W-1:0] addr_q, addr_d;
    logic [WIDX_W-1:0] end_q, end_d;
    logic              err_q, err_d;
    logic              ndone_q, ndone_d;
    logic              done_q, done_d;
    logic              last;
    logic              finish;

    assign last = (state_q == StStream) && (addr_q == end_q - WIDX_W'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        addr_d  = addr_q;
        end_d   = end_q;
        err_d   = err_q;
        ndone_d = 1'b0;
        done_d  = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StLookup;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            StLookup: state_d = StLatch;
            StLatch: begin
                addr_d = bus.begin_index;
                end_d  = bus.end_index;
                id_d   = cnt_q;
                if (bus.begin_index < bus.end_index) begin
                    state_d = StStream;
                end else begin
                    finish = 1'b1;
                    if (bus.begin_index > bus.end_index) err_d = 1'b1;
                end
            end
            StStream: begin
                if (bus.addr_ready) begin
                    addr_d = addr_q + WIDX_W'(1);
                    if (last) finish = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Next lookup overlaps the neuron_done pulse of the neuron just finished.
        if (finish) begin
            ndone_d = 1'b1;
            if (cnt_q == LastNeuron) begin
                done_d  = 1'b1;
                state_d = StIdle;
            end else begin
                cnt_d   = cnt_q + NIDX_W'(1);
                state_d = StLookup;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            id_q    <= '0;
            addr_q  <= '0;
            end_q   <= '0;
            err_q   <= 1'b0;
            ndone_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            err_q   <= err_d;
            ndone_q <= ndone_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy         = (state_q != StIdle);
    assign bus.neuron_index = cnt_q;
    assign bus.addr         = addr_q;
    assign bus.addr_valid   = (state_q == StStream);
    assign bus.addr_last    = last;
    assign bus.neuron_id    = id_q;
    assign bus.neuron_done  = ndone_q;
    assign bus.done         = done_q;
    assign bus.range_err    = err_q;
endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Directed and randomized sweeps of weight_fetch_sequencer against an address-list model
// derived from the index table.
module tb_weight_fetch_sequencer;
    localparam int N = 40;

    typedef struct {
        logic [7:0] a;
        logic       l;
        logic [5:0] id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   first_valid_k;
    int   first_nd_k;
    logic [7:0] tbl [0:N];
    exp_t exp_q [$];

    weight_fetch_sequencer_if #(.NIDX_W(6), .WIDX_W(8)) bus ();

    weight_fetch_sequencer #(.NUM_NEURONS(N), .NIDX_W(6), .WIDX_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Weight-index memory: registered read of entries i and i+1.
    always @(posedge clk) begin
        bus.begin_index <= tbl[int'(bus.neuron_index)];
        bus.end_index   <= tbl[int'(bus.neuron_index) + 1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_neuron_index"}, 32'(bus.neuron_index), 0);
        check({tag, "_addr"}, 32'(bus.addr), 0);
        check({tag, "_addr_valid"}, 32'(bus.addr_valid), 0);
        check({tag, "_addr_last"}, 32'(bus.addr_last), 0);
        check({tag, "_neuron_id"}, 32'(bus.neuron_id), 0);
        check({tag, "_neuron_done"}, 32'(bus.neuron_done), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_range_err"}, 32'(bus.range_err), 0);
    endtask

    task automatic table_a();
        tbl[0] = 8'd0; tbl[1] = 8'd3; tbl[2] = 8'd3; tbl[3] = 8'd7;
        for (int i = 3; i < N; i++) tbl[i+1] = tbl[i] + ((i < 11) ? 8'd6 : 8'd5);
    endtask

    task automatic table_rand();
        tbl[0] = 8'($urandom_range(0, 3));
        for (int i = 1; i <= N; i++) tbl[i] = tbl[i-1] + 8'($urandom_range(0, 5));
    endtask

    task automatic run_sweep(input bit rnd_ready, input bit glitch, input int abort_id);
        bit         bad_upto [N];
        bit         any_bad = 1'b0;
        bit         finished = 1'b0;
        bit         aborted = 1'b0;
        bit         glitched = 1'b0;
        bit         prev_stall = 1'b0;
        bit         r;
        logic [7:0] p_addr = '0;
        logic       p_last = 1'b0;
        logic [5:0] p_id = '0;
        int         k, nd = 0, hs = 0, total, extra;
        exp_t       e;

        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            int b = int'(tbl[i]);
            int en = int'(tbl[i+1]);
            if (b > en) any_bad = 1'b1;
            bad_upto[i] = any_bad;
            for (int a = b; a < en; a++) exp_q.push_back('{8'(a), a == en - 1, 6'(i)});
        end
        total = exp_q.size();
        first_valid_k = -1;
        first_nd_k = -1;

        @(negedge clk);
        bus.start = 1'b1;
        bus.addr_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        k = 1;
        check("busy_after_start", 32'(bus.busy), 1);
        check("range_err_cleared", 32'(bus.range_err), 0);

        while (k < 5000 && !finished && !aborted) begin
            if (abort_id >= 0 && bus.addr_valid && int'(bus.neuron_id) == abort_id) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                check_idle("abort");
                @(negedge clk);
                rst = 1'b0;
                aborted = 1'b1;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 32'(bus.addr_valid), 1);
                    check("stall_addr", 32'(bus.addr), 32'(p_addr));
                    check("stall_last", 32'(bus.addr_last), 32'(p_last));
                    check("stall_id", 32'(bus.neuron_id), 32'(p_id));
                end
                if (bus.addr_valid && first_valid_k < 0) first_valid_k = k;
                if (bus.neuron_done) begin
                    if (first_nd_k < 0) first_nd_k = k;
                    check("nd_id", 32'(bus.neuron_id), 32'(nd));
                    if (nd < N) check("nd_range_err", 32'(bus.range_err), 32'(bad_upto[nd]));
                    nd++;
                end
                if (bus.done) begin
                    finished = 1'b1;
                    check("done_neuron_count", 32'(nd), N);
                    check("done_handshakes", 32'(hs), 32'(total));
                    check("done_busy", 32'(bus.busy), 0);
                    check("done_range_err", 32'(bus.range_err), 32'(any_bad));
                    if (!rnd_ready) check("done_cycle", 32'(k), 32'(1 + 2 * N + total));
                end else begin
                    r = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                    bus.addr_ready = r;
                    bus.start = glitch && !glitched && k >= 10 && bus.addr_valid;
                    if (bus.start) glitched = 1'b1;
                    if (bus.addr_valid && r) begin
                        if (exp_q.size() == 0) begin
                            check("extra_addr", 32'(bus.addr_valid), 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("hs_addr", 32'(bus.addr), 32'(e.a));
                            check("hs_last", 32'(bus.addr_last), 32'(e.l));
                            check("hs_id", 32'(bus.neuron_id), 32'(e.id));
                        end
                        hs++;
                    end
                    prev_stall = bus.addr_valid && !r;
                    p_addr = bus.addr;
                    p_last = bus.addr_last;
                    p_id = bus.neuron_id;
                    @(negedge clk);
                    k++;
                end
            end
        end

        if (!aborted) begin
            check("sweep_timeout", 32'(finished), 1);
            bus.start = 1'b0;
            extra = 0;
            repeat (30) begin
                @(negedge clk);
                if (bus.done || bus.busy) extra++;
            end
            check("no_extra_done", 32'(extra), 0);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.addr_ready = 1'b0;
        table_a();
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        // Table 0,3,3,7,... with 200 weights total, ready held high.
        run_sweep(1'b0, 1'b0, -1);
        check("first_valid_cycle", 32'(first_valid_k), 3);
        check("first_neuron_done_cycle", 32'(first_nd_k), 6);

        // Same table, random backpressure.
        run_sweep(1'b1, 1'b0, -1);

        // Inverted and end=0 ranges, random backpressure.
        table_rand();
        tbl[5] = 8'd9;
        tbl[6] = 8'd5;
        tbl[20] = 8'd0;
        tbl[N] = 8'd255;
        run_sweep(1'b1, 1'b0, -1);
        check("range_err_sticky", 32'(bus.range_err), 1);

        // Start pulse during streaming must be ignored.
        table_rand();
        run_sweep(1'b0, 1'b1, -1);

        // Reset mid-stream of neuron 17, then restart from neuron 0.
        table_a();
        run_sweep(1'b1, 1'b0, 17);
        run_sweep(1'b0, 1'b0, -1);
        check("restart_first_valid_cycle", 32'(first_valid_k), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
